// File: rtl/hazard_pkg.sv
// Shared types and constants for the core hazard/sequencing controller.
package hazard_pkg;
    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_W    = 2'b01,
        FWD_M    = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: register ids and enables in, controls out.
interface hazard_ctrl_if
    import hazard_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) ();
    logic [4:0]           Rs1D, Rs2D, Rs1E, Rs2E;
    logic [4:0]           RdE, RdM, RdW;
    logic                 RegWriteM, RegWriteW;
    logic [1:0]           ResultSrcE;
    logic                 PCSrcE;
    logic                 MulDivE;
    fwd_sel_t             ForwardAE, ForwardBE;
    logic                 StallF, StallD, StallE;
    logic                 FlushD, FlushE, FlushM;
    logic                 MDStartE, MDDoneE;
    logic [CNT_WIDTH-1:0] StallCount;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
               RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MulDivE,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE,
               FlushD, FlushE, FlushM, MDStartE, MDDoneE, StallCount
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
               RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MulDivE,
        output ForwardAE, ForwardBE, StallF, StallD, StallE,
               FlushD, FlushE, FlushM, MDStartE, MDDoneE, StallCount
    );
endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding select for one E-stage operand; the younger M result beats W.
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    output fwd_sel_t   sel
);
    always_comb begin
        sel = FWD_NONE;
        if (reg_write_m && rd_m != 5'd0 && rd_m == rs)
            sel = FWD_M;
        else if (reg_write_w && rd_w != 5'd0 && rd_w == rs)
            sel = FWD_W;
    end
endmodule

// File: rtl/hazard_ctrl.sv
// Forwarding, load-use/branch/multi-cycle stall and flush control, plus a stall-cycle counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = 4,
    parameter int CNT_WIDTH  = 32
) (
    input logic         clk,
    input logic         reset,
    hazard_ctrl_if.slave hif
);
    localparam logic [3:0] CNT_INIT = 4'(MD_LATENCY - 2);

    md_state_t  state;
    logic [3:0] cnt;
    fwd_sel_t   fwd_a, fwd_b;
    logic       lw_stall, md_stall, md_start, md_done;

    fwd_sel u_fwd_a (
        .rs(hif.Rs1E), .rd_m(hif.RdM), .rd_w(hif.RdW),
        .reg_write_m(hif.RegWriteM), .reg_write_w(hif.RegWriteW), .sel(fwd_a)
    );

    fwd_sel u_fwd_b (
        .rs(hif.Rs2E), .rd_m(hif.RdM), .rd_w(hif.RdW),
        .reg_write_m(hif.RegWriteM), .reg_write_w(hif.RegWriteW), .sel(fwd_b)
    );

    assign lw_stall = (hif.ResultSrcE == RESULT_SRC_LOAD) && (hif.RdE != 5'd0) &&
                      ((hif.RdE == hif.Rs1D) || (hif.RdE == hif.Rs2D));
    assign md_start = (state == IDLE) && hif.MulDivE;
    assign md_done  = (state == BUSY) && (cnt == 4'd0);
    assign md_stall = md_start || ((state == BUSY) && (cnt != 4'd0));

    always_comb begin
        hif.ForwardAE = fwd_a;
        hif.ForwardBE = fwd_b;
        hif.StallF    = 1'b0;
        hif.StallD    = 1'b0;
        hif.StallE    = 1'b0;
        hif.FlushD    = 1'b0;
        hif.FlushE    = 1'b0;
        hif.FlushM    = 1'b0;
        hif.MDStartE  = md_start;
        hif.MDDoneE   = md_done;
        if (reset) begin
            // Hold bubbles in every stage while the core comes out of reset.
            hif.ForwardAE = FWD_NONE;
            hif.ForwardBE = FWD_NONE;
            hif.FlushD    = 1'b1;
            hif.FlushE    = 1'b1;
            hif.FlushM    = 1'b1;
            hif.MDStartE  = 1'b0;
            hif.MDDoneE   = 1'b0;
        end else if (md_stall) begin
            // The op sitting in E is never flushed, not even by a branch.
            hif.StallF = 1'b1;
            hif.StallD = 1'b1;
            hif.StallE = 1'b1;
            hif.FlushM = 1'b1;
        end else if (hif.PCSrcE) begin
            hif.FlushD = 1'b1;
            hif.FlushE = 1'b1;
        end else if (lw_stall) begin
            hif.StallF = 1'b1;
            hif.StallD = 1'b1;
            hif.FlushE = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: if (hif.MulDivE) begin
                    state <= BUSY;
                    cnt   <= CNT_INIT;
                end
                BUSY: if (cnt != 4'd0) cnt <= cnt - 4'd1;
                      else             state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            hif.StallCount <= '0;
        else if (hif.StallD)
            hif.StallCount <= hif.StallCount + 1'b1;
    end

`ifndef SYNTHESIS
    md_known: assert property (@(posedge clk) disable iff (reset)
        (state == IDLE) |-> !$isunknown(hif.MulDivE));
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboarded bench for hazard_ctrl: expected controls queued per drive, compared at negedge.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int LAT = 4;
    localparam int CW  = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_WIDTH(CW)) hif ();

    hazard_ctrl #(.MD_LATENCY(LAT), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .hif(hif.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [11:0]   exp_q[$];
    logic [CW-1:0] cnt_q[$];
    int            md_phase = -1;
    logic [CW-1:0] m_cnt    = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] fwd_of(input logic [4:0] rs);
        if (hif.RegWriteM && hif.RdM != 0 && hif.RdM == rs) return 2'b10;
        if (hif.RegWriteW && hif.RdW != 0 && hif.RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clr();
        hif.Rs1D = 0; hif.Rs2D = 0; hif.Rs1E = 0; hif.Rs2E = 0;
        hif.RdE = 0; hif.RdM = 0; hif.RdW = 0;
        hif.RegWriteM = 0; hif.RegWriteW = 0; hif.ResultSrcE = 0;
        hif.PCSrcE = 0; hif.MulDivE = 0;
    endtask

    // One cycle: model the expected outputs from current inputs, check at negedge, advance.
    task automatic step(input string tag);
        logic [1:0] fa, fb;
        logic sf, sd, se, fd, fe, fm, ms, mdn, lw, mds;
        int   ph;
        logic [11:0] got;
        fa = 0; fb = 0; sf = 0; sd = 0; se = 0; fd = 0; fe = 0; fm = 0; ms = 0; mdn = 0;
        ph = -1;
        if (reset) begin
            fd = 1; fe = 1; fm = 1;
        end else begin
            fa = fwd_of(hif.Rs1E);
            fb = fwd_of(hif.Rs2E);
            ph = (md_phase < 0) ? (hif.MulDivE ? 0 : -1) : md_phase;
            ms  = (ph == 0) && (md_phase < 0);
            mds = (ph >= 0) && (ph < LAT - 1);
            mdn = (ph == LAT - 1);
            lw  = (hif.ResultSrcE == 2'b01) && hif.RdE != 0 &&
                  (hif.RdE == hif.Rs1D || hif.RdE == hif.Rs2D);
            if (mds) begin sf = 1; sd = 1; se = 1; fm = 1; end
            else if (hif.PCSrcE) begin fd = 1; fe = 1; end
            else if (lw) begin sf = 1; sd = 1; fe = 1; end
        end
        exp_q.push_back({fa, fb, sf, sd, se, fd, fe, fm, ms, mdn});
        cnt_q.push_back(m_cnt);
        @(negedge clk);
        got = {hif.ForwardAE, hif.ForwardBE, hif.StallF, hif.StallD, hif.StallE,
               hif.FlushD, hif.FlushE, hif.FlushM, hif.MDStartE, hif.MDDoneE};
        chk({tag, ".ctl"}, 32'(got), 32'(exp_q.pop_front()));
        chk({tag, ".cnt"}, 32'(hif.StallCount), 32'(cnt_q.pop_front()));
        if (reset) begin
            m_cnt = '0; md_phase = -1;
        end else begin
            if (sd) m_cnt = m_cnt + 1'b1;
            if (ph >= 0) md_phase = (ph == LAT - 1) ? -1 : ph + 1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        clr();
        reset = 1;
        @(posedge clk); #1;
        step("rst0");
        step("rst1");
        reset = 0;
        step("idle");

        // forwarding priority and x0 suppression
        hif.RdM = 5; hif.RdW = 5; hif.RegWriteM = 1; hif.RegWriteW = 1; hif.Rs1E = 5; hif.Rs2E = 6;
        step("fwd_m");
        chk("fwd_m_dir", 32'(hif.ForwardAE), 32'h2);
        hif.RegWriteM = 0;
        step("fwd_w");
        chk("fwd_w_dir", 32'(hif.ForwardAE), 32'h1);
        hif.RegWriteM = 1; hif.RdM = 0; hif.RdW = 0; hif.Rs1E = 0; hif.Rs2E = 0;
        step("fwd_x0");
        clr();

        // load-use for a single cycle
        hif.ResultSrcE = 2'b01; hif.RdE = 7; hif.Rs2D = 7;
        step("lw");
        clr();
        step("lw_after");
        chk("lw_cnt_dir", 32'(hif.StallCount), 32'h1);

        // taken branch beats load-use
        hif.ResultSrcE = 2'b01; hif.RdE = 7; hif.Rs1D = 7; hif.PCSrcE = 1;
        step("br_lw");
        clr();

        // two back-to-back multi-cycle ops, branch during BUSY is ignored
        hif.MulDivE = 1;
        for (int i = 0; i < 2 * LAT; i++) begin
            hif.PCSrcE = (i == 1);
            step($sformatf("md%0d", i));
        end
        clr();
        step("md_end");

        // reset abandons an in-flight op
        hif.MulDivE = 1;
        step("mdr0");
        step("mdr1");
        reset = 1;
        step("mdr_rst");
        reset = 0; hif.MulDivE = 0;
        step("mdr_idle");
        step("mdr_idle2");

        // counter wrap: 17 stall cycles on a 4-bit counter
        reset = 1; step("wrap_rst"); reset = 0;
        hif.ResultSrcE = 2'b01; hif.RdE = 3; hif.Rs1D = 3;
        for (int i = 0; i < 17; i++) step("wrap");
        clr();
        chk("wrap_dir", 32'(hif.StallCount), 32'h1);
        step("wrap_end");

        // random traffic
        for (int i = 0; i < 200; i++) begin
            hif.Rs1D = 5'($urandom_range(0, 3)); hif.Rs2D = 5'($urandom_range(0, 3));
            hif.Rs1E = 5'($urandom_range(0, 3)); hif.Rs2E = 5'($urandom_range(0, 3));
            hif.RdE = 5'($urandom_range(0, 3)); hif.RdM = 5'($urandom_range(0, 3));
            hif.RdW = 5'($urandom_range(0, 3));
            hif.RegWriteM = 1'($urandom); hif.RegWriteW = 1'($urandom);
            hif.ResultSrcE = 2'($urandom);
            hif.PCSrcE  = ($urandom_range(0, 4) == 0);
            hif.MulDivE = ($urandom_range(0, 3) == 0);
            reset       = ($urandom_range(0, 29) == 0);
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
